// File: rtl/gemm_ab_sequencer.sv
// gemm_ab_sequencer: control FSM that walks the A/B operand RAMs for a DIMxDIM GEMM,
// producing two C rows per pass (rows 2p and 2p+1 through the two A read ports).
// MAC strobes are delayed one cycle to line up with the registered RAM read data.
// C write strobes and addresses come one cycle after that.
// Optional build macro SEQ_STALL_CNT_EN adds a saturating 16-bit hold counter output stall_cnt.
module gemm_ab_sequencer #(
  parameter int DIM = 8,
  parameter int AW  = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          hold,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] a_addr_1,
  output logic [AW-1:0] a_addr_2,
  output logic [AW-1:0] b_addr,
  output logic          mac_en,
  output logic          mac_first,
  output logic          c_we,
  output logic [AW-1:0] c_addr_1,
  output logic [AW-1:0] c_addr_2
`ifdef SEQ_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  localparam int KW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int PW = (DIM > 2) ? $clog2(DIM / 2) : 1;
  localparam logic [KW-1:0] K_LAST   = KW'(DIM - 1);
  localparam logic [PW-1:0] P_LAST   = PW'(DIM / 2 - 1);
  localparam logic [AW-1:0] ROW_STEP = AW'(DIM);
  localparam logic [AW-1:0] PAIR_STEP = AW'(2 * DIM);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pCnt_q, pCnt_d;
  logic [KW-1:0] jCnt_q, jCnt_d;
  logic [KW-1:0] kCnt_q, kCnt_d;
  logic          drainCnt_q, drainCnt_d;
  logic          issue;

  logic          v1_q;
  logic          first1_q;
  logic          last1_q;
  logic [PW-1:0] p1_q;
  logic [KW-1:0] j1_q;

  logic          cWe_q;
  logic [AW-1:0] cAddr1_q;
  logic [AW-1:0] cAddr2_q;

  logic [AW-1:0] aRow1Addr;
  logic [AW-1:0] bColAddr;
  logic [AW-1:0] cRow1Addr;
  logic          inIssue;
  logic          writeNow;

  // Operand addresses: row 2p and 2p+1 of A at column k, row k of B at column j.
  assign aRow1Addr = AW'(pCnt_q) * PAIR_STEP + AW'(kCnt_q);
  assign bColAddr  = AW'(kCnt_q) * ROW_STEP + AW'(jCnt_q);
  assign cRow1Addr = AW'(p1_q) * PAIR_STEP + AW'(j1_q);
  assign inIssue   = (state_q == ISSUE);
  assign writeNow  = v1_q & last1_q;

  // Next-state and counter logic; only ISSUE cycles without hold advance (p,j,k).
  always_comb begin
    state_d    = state_q;
    pCnt_d     = pCnt_q;
    jCnt_d     = jCnt_q;
    kCnt_d     = kCnt_q;
    drainCnt_d = drainCnt_q;
    issue      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          pCnt_d  = '0;
          jCnt_d  = '0;
          kCnt_d  = '0;
        end
      end
      ISSUE: begin
        if (!hold) begin
          issue = 1'b1;
          if (kCnt_q == K_LAST) begin
            kCnt_d = '0;
            if (jCnt_q == K_LAST) begin
              jCnt_d = '0;
              if (pCnt_q == P_LAST) begin
                pCnt_d     = '0;
                drainCnt_d = 1'b0;
                state_d    = DRAIN;
              end else begin
                pCnt_d = pCnt_q + 1'b1;
              end
            end else begin
              jCnt_d = jCnt_q + 1'b1;
            end
          end else begin
            kCnt_d = kCnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drainCnt_q) begin
          drainCnt_d = 1'b0;
          state_d    = DONE;
        end else begin
          drainCnt_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and loop counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pCnt_q     <= '0;
      jCnt_q     <= '0;
      kCnt_q     <= '0;
      drainCnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pCnt_q     <= pCnt_d;
      jCnt_q     <= jCnt_d;
      kCnt_q     <= kCnt_d;
      drainCnt_q <= drainCnt_d;
    end
  end

  // Two-stage strobe pipeline: stage 1 matches RAM read latency, stage 2 follows the last MAC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
      p1_q     <= '0;
      j1_q     <= '0;
      cWe_q    <= 1'b0;
      cAddr1_q <= '0;
      cAddr2_q <= '0;
    end else begin
      v1_q     <= issue;
      first1_q <= (kCnt_q == '0);
      last1_q  <= (kCnt_q == K_LAST);
      p1_q     <= pCnt_q;
      j1_q     <= jCnt_q;
      cWe_q    <= writeNow;
      cAddr1_q <= writeNow ? cRow1Addr : '0;
      cAddr2_q <= writeNow ? (cRow1Addr + ROW_STEP) : '0;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign a_addr_1  = inIssue ? aRow1Addr : '0;
  assign a_addr_2  = inIssue ? (aRow1Addr + ROW_STEP) : '0;
  assign b_addr    = inIssue ? bColAddr : '0;
  assign mac_en    = v1_q;
  assign mac_first = v1_q & first1_q;
  assign c_we      = cWe_q;
  assign c_addr_1  = cAddr1_q;
  assign c_addr_2  = cAddr2_q;

`ifdef SEQ_STALL_CNT_EN
  logic [15:0] stallCnt_q, stallCnt_d;

  // Count held ISSUE cycles for the current run, saturating rather than wrapping.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if ((state_q == IDLE) && start) begin
      stallCnt_d = '0;
    end else if (inIssue && hold && (stallCnt_q != 16'hFFFF)) begin
      stallCnt_d = stallCnt_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stallCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
    end
  end

  assign stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_gemm_ab_sequencer.sv
// tb_gemm_ab_sequencer: directed checks of the GEMM A/B sequencer timing, addresses,
// hold, restart-while-busy and mid-run reset. It also runs a RAM+MAC model that must
// reproduce A when B is the identity matrix.
module tb_gemm_ab_sequencer;

  localparam int DIM  = 8;
  localparam int AW   = 6;
  localparam int NVEC = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          hold;
  logic          busy;
  logic          done;
  logic [AW-1:0] a_addr_1;
  logic [AW-1:0] a_addr_2;
  logic [AW-1:0] b_addr;
  logic          mac_en;
  logic          mac_first;
  logic          c_we;
  logic [AW-1:0] c_addr_1;
  logic [AW-1:0] c_addr_2;
`ifdef SEQ_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  gemm_ab_sequencer #(.DIM(DIM), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .hold      (hold),
    .busy      (busy),
    .done      (done),
    .a_addr_1  (a_addr_1),
    .a_addr_2  (a_addr_2),
    .b_addr    (b_addr),
    .mac_en    (mac_en),
    .mac_first (mac_first),
    .c_we      (c_we),
    .c_addr_1  (c_addr_1),
    .c_addr_2  (c_addr_2)
`ifdef SEQ_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Expected outputs at a given cycle offset after the start-sampling edge.
  typedef struct {
    int rel;
    int a1;
    int a2;
    int b;
    int macEn;
    int macFirst;
    int cWe;
    int c1;
    int c2;
    int busyExp;
    int doneExp;
  } vecT;

  vecT vecs [NVEC];

  int checks   = 0;
  int failures = 0;

  logic signed [7:0] ramA [DIM*DIM];
  logic signed [7:0] ramB [DIM*DIM];
  int                cModel [DIM*DIM];
  bit                cWritten [DIM*DIM];

  int doneRel;
  int doneCount;
  int cweCount;
  int writtenCount;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A port 1 / B address of the n-th issue (1-based) in a hold-free walk.
  function automatic int expA1(input int n);
    int m;
    m = n - 1;
    return (m / (DIM * DIM)) * 2 * DIM + (m % DIM);
  endfunction

  function automatic int expB(input int n);
    int m;
    m = n - 1;
    return (m % DIM) * DIM + ((m / DIM) % DIM);
  endfunction

  // Run one GEMM from a start pulse, optionally with hold, a second start, or a reset.
  task automatic applyStimulus(input int holdAt, input int holdLen, input int restartAt,
                               input int resetAt, input bit useTable, input int maxRel,
                               output int dRel, output int dCount, output int wCount);
    int acc1, acc2, prod1, prod2;
    int prevA1, prevA2, prevB;
    dRel   = -1;
    dCount = 0;
    wCount = 0;
    acc1   = 0;
    acc2   = 0;
    prevA1 = 0;
    prevA2 = 0;
    prevB  = 0;
    for (int i = 0; i < DIM * DIM; i++) begin
      cModel[i]   = 0;
      cWritten[i] = 1'b0;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int rel = 1; rel <= maxRel; rel++) begin
      hold  = (rel >= holdAt) && (rel < holdAt + holdLen);
      start = (rel == restartAt);
      rst_n = (rel != resetAt);
      if (useTable) begin
        for (int v = 0; v < NVEC; v++) begin
          if (vecs[v].rel == rel) begin
            checkOutput($sformatf("a_addr_1@%0d", rel), a_addr_1, vecs[v].a1);
            checkOutput($sformatf("a_addr_2@%0d", rel), a_addr_2, vecs[v].a2);
            checkOutput($sformatf("b_addr@%0d", rel), b_addr, vecs[v].b);
            checkOutput($sformatf("mac_en@%0d", rel), mac_en, vecs[v].macEn);
            checkOutput($sformatf("mac_first@%0d", rel), mac_first, vecs[v].macFirst);
            checkOutput($sformatf("c_we@%0d", rel), c_we, vecs[v].cWe);
            checkOutput($sformatf("c_addr_1@%0d", rel), c_addr_1, vecs[v].c1);
            checkOutput($sformatf("c_addr_2@%0d", rel), c_addr_2, vecs[v].c2);
            checkOutput($sformatf("busy@%0d", rel), busy, vecs[v].busyExp);
            checkOutput($sformatf("done@%0d", rel), done, vecs[v].doneExp);
          end
        end
      end
      if (holdLen > 0) begin
        if (rel == holdAt) checkOutput("mac_en with hold after issue", mac_en, 1);
        if (rel > holdAt && rel <= holdAt + holdLen) begin
          checkOutput($sformatf("held a_addr_1@%0d", rel), a_addr_1, expA1(holdAt));
          checkOutput($sformatf("held b_addr@%0d", rel), b_addr, expB(holdAt));
          checkOutput($sformatf("held mac_en@%0d", rel), mac_en, 0);
        end
        if (rel == holdAt + holdLen + 1) checkOutput("mac_en after hold", mac_en, 1);
      end
      if (resetAt > 0 && rel == resetAt + 1) begin
        checkOutput("post-reset busy", busy, 0);
        checkOutput("post-reset done", done, 0);
        checkOutput("post-reset mac_en", mac_en, 0);
        checkOutput("post-reset mac_first", mac_first, 0);
        checkOutput("post-reset c_we", c_we, 0);
        checkOutput("post-reset a_addr_1", a_addr_1, 0);
        checkOutput("post-reset a_addr_2", a_addr_2, 0);
        checkOutput("post-reset b_addr", b_addr, 0);
        checkOutput("post-reset c_addr_1", c_addr_1, 0);
        checkOutput("post-reset c_addr_2", c_addr_2, 0);
      end
      if (c_we === 1'b1) begin
        wCount++;
        cModel[c_addr_1]   = acc1;
        cModel[c_addr_2]   = acc2;
        cWritten[c_addr_1] = 1'b1;
        cWritten[c_addr_2] = 1'b1;
      end
      if (mac_en === 1'b1) begin
        prod1 = int'(ramA[prevA1]) * int'(ramB[prevB]);
        prod2 = int'(ramA[prevA2]) * int'(ramB[prevB]);
        acc1  = (mac_first === 1'b1) ? prod1 : acc1 + prod1;
        acc2  = (mac_first === 1'b1) ? prod2 : acc2 + prod2;
      end
      prevA1 = int'(a_addr_1);
      prevA2 = int'(a_addr_2);
      prevB  = int'(b_addr);
      if (done === 1'b1) begin
        dCount++;
        if (dRel < 0) dRel = rel;
      end
      step();
    end
    hold  = 1'b0;
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{1,   0,  8,  0,  0, 0, 0, 0,  0,  1, 0};
    vecs[1]  = '{2,   1,  9,  8,  1, 1, 0, 0,  0,  1, 0};
    vecs[2]  = '{3,   2,  10, 16, 1, 0, 0, 0,  0,  1, 0};
    vecs[3]  = '{8,   7,  15, 56, 1, 0, 0, 0,  0,  1, 0};
    vecs[4]  = '{9,   0,  8,  1,  1, 0, 0, 0,  0,  1, 0};
    vecs[5]  = '{10,  1,  9,  9,  1, 1, 1, 0,  8,  1, 0};
    vecs[6]  = '{11,  2,  10, 17, 1, 0, 0, 0,  0,  1, 0};
    vecs[7]  = '{18,  1,  9,  10, 1, 1, 1, 1,  9,  1, 0};
    vecs[8]  = '{65,  16, 24, 0,  1, 0, 0, 0,  0,  1, 0};
    vecs[9]  = '{66,  17, 25, 8,  1, 1, 1, 7,  15, 1, 0};
    vecs[10] = '{74,  17, 25, 9,  1, 1, 1, 16, 24, 1, 0};
    vecs[11] = '{256, 55, 63, 63, 1, 0, 0, 0,  0,  1, 0};
    vecs[12] = '{257, 0,  0,  0,  1, 0, 0, 0,  0,  1, 0};
    vecs[13] = '{258, 0,  0,  0,  0, 0, 1, 55, 63, 1, 0};
    vecs[14] = '{259, 0,  0,  0,  0, 0, 0, 0,  0,  1, 1};
    vecs[15] = '{260, 0,  0,  0,  0, 0, 0, 0,  0,  0, 0};

    for (int i = 0; i < DIM * DIM; i++) begin
      ramA[i] = 8'(i * 37 - 100);
      ramB[i] = ((i / DIM) == (i % DIM)) ? 8'sd1 : 8'sd0;
    end

    rst_n = 1'b0;
    start = 1'b0;
    hold  = 1'b0;
    step();
    step();
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset mac_en", mac_en, 0);
    checkOutput("reset c_we", c_we, 0);
    checkOutput("reset a_addr_2", a_addr_2, 0);
    checkOutput("reset c_addr_2", c_addr_2, 0);
    rst_n = 1'b1;
    step();

    $display("[TB] full run, no hold");
    applyStimulus(0, 0, 0, 0, 1'b1, 265, doneRel, doneCount, cweCount);
    checkOutput("full done cycle", doneRel, 259);
    checkOutput("full done count", doneCount, 1);
    checkOutput("full c_we count", cweCount, 32);
    writtenCount = 0;
    for (int i = 0; i < DIM * DIM; i++) begin
      if (cWritten[i]) writtenCount++;
      checkOutput($sformatf("C[%0d]", i), cModel[i], int'(ramA[i]));
    end
    checkOutput("C entries written", writtenCount, DIM * DIM);

    $display("[TB] hold for 3 cycles at k=5");
    applyStimulus(6, 3, 0, 0, 1'b0, 268, doneRel, doneCount, cweCount);
    checkOutput("hold done cycle", doneRel, 262);
    checkOutput("hold done count", doneCount, 1);
    checkOutput("hold c_we count", cweCount, 32);
`ifdef SEQ_STALL_CNT_EN
    checkOutput("stall_cnt", stall_cnt, 3);
`endif

    $display("[TB] start pulsed while busy");
    applyStimulus(0, 0, 50, 0, 1'b0, 265, doneRel, doneCount, cweCount);
    checkOutput("restart done cycle", doneRel, 259);
    checkOutput("restart done count", doneCount, 1);
    checkOutput("restart c_we count", cweCount, 32);

    $display("[TB] reset at cycle 100");
    applyStimulus(0, 0, 0, 100, 1'b0, 130, doneRel, doneCount, cweCount);
    checkOutput("aborted done count", doneCount, 0);
    checkOutput("aborted c_we count", cweCount, 12);

    $display("[TB] full run after abort");
    applyStimulus(0, 0, 0, 0, 1'b1, 265, doneRel, doneCount, cweCount);
    checkOutput("rerun done cycle", doneRel, 259);
    checkOutput("rerun done count", doneCount, 1);
    checkOutput("rerun c_we count", cweCount, 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the bench always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
